// File: rtl/program_sequencer_pkg.sv
// Shared ISA definitions for the program sequencer and the cell cores.
// The opcode occupies the top nibble of an instruction and the low bits carry the branch target.
package program_sequencer_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int STACK_DEPTH  = 32;

    // Cell-core register codes
    localparam logic [3:0] REG_ZERO = 4'h0;
    localparam logic [3:0] REG_ACC  = 4'h1;
    localparam logic [3:0] REG_TMP  = 4'h2;
    localparam logic [3:0] REG_NBR  = 4'h3;

    // Sequencer control opcodes; anything else is a plain cell operation
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_BR   = 4'h2;
    localparam logic [3:0] OP_CALL = 4'h3;
    localparam logic [3:0] OP_RET  = 4'h4;
    localparam logic [3:0] OP_END  = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_FAULT
    } seq_state_t;

endpackage

// File: rtl/sequencer_stack.sv
// Return-address stack for CALL/RET; storage is not reset, only the pointer is.
// Latency: push/pop take effect on the next edge; top_data is combinational.
// Backpressure: none; push when full and pop when empty are ignored.
module sequencer_stack
    import program_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 12,
    parameter int SP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top_data,
    output logic [SP_WIDTH-1:0] sp,
    output logic                full,
    output logic                empty
);

    logic [PC_WIDTH-1:0] mem [STACK_DEPTH];

    // The last slot is kept free so that sp never wraps.
    assign full     = (sp == SP_WIDTH'(STACK_DEPTH - 1));
    assign empty    = (sp == '0);
    assign top_data = mem[sp - SP_WIDTH'(1)];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_WIDTH'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_WIDTH'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Broadcast program sequencer: fetches from ROM and drives one instruction per 2 cycles to the cell array.
// Latency: FETCH then EXEC per instruction; next PC/SP are combinational during EXEC.
// Backpressure: none; start is ignored unless idle, and FAULT holds until rst.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = 12,
    parameter int SP_WIDTH    = 5,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    next_program_counter,
    output logic [SP_WIDTH-1:0]    next_stack_pointer,
    output logic                   execution_enable,
    input  logic                   branch_any,
    input  logic                   diverge_any,
    output logic                   busy,
    output logic                   generation_done,
    output logic                   fault
);

    seq_state_t              state, state_nxt;
    logic [PC_WIDTH-1:0]     pc, pc_inc, target, stack_top;
    logic [SP_WIDTH-1:0]     sp;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    stack_full, stack_empty, stack_push, stack_pop, stack_err;
    logic                    load_instr, advance, restart, retire_end, set_fault;

    assign opcode = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign target = instruction[PC_WIDTH-1:0];
    assign pc_inc = pc + PC_WIDTH'(1);
    assign busy   = (state == ST_FETCH) || (state == ST_EXEC);

    // Presenting the next PC during EXEC lets a registered ROM have data ready in FETCH.
    assign imem_addr = advance ? next_program_counter : pc;

    always_comb begin
        next_program_counter = pc_inc;
        next_stack_pointer   = sp;
        stack_err            = 1'b0;
        case (opcode)
            OP_JMP: next_program_counter = target;
            OP_BR: begin
                if (branch_any) begin
                    next_program_counter = target;
                end
            end
            OP_CALL: begin
                if (stack_full) begin
                    stack_err = 1'b1;
                end else begin
                    next_program_counter = target;
                    next_stack_pointer   = sp + SP_WIDTH'(1);
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    stack_err = 1'b1;
                end else begin
                    next_program_counter = stack_top;
                    next_stack_pointer   = sp - SP_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt        = state;
        execution_enable = 1'b0;
        load_instr       = 1'b0;
        advance          = 1'b0;
        restart          = 1'b0;
        retire_end       = 1'b0;
        set_fault        = 1'b0;
        stack_push       = 1'b0;
        stack_pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    restart   = 1'b1;
                end
            end
            ST_FETCH: begin
                load_instr = 1'b1;
                state_nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                execution_enable = 1'b1;
                if (stack_err || (opcode == OP_END && diverge_any)) begin
                    state_nxt = ST_FAULT;
                    set_fault = 1'b1;
                end else if (opcode == OP_END) begin
                    state_nxt  = ST_IDLE;
                    retire_end = 1'b1;
                end else begin
                    state_nxt  = ST_FETCH;
                    advance    = 1'b1;
                    stack_push = (opcode == OP_CALL);
                    stack_pop  = (opcode == OP_RET);
                end
            end
            default: state_nxt = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            pc              <= '0;
            instruction     <= '0;
            fault           <= 1'b0;
            generation_done <= 1'b0;
        end else begin
            state           <= state_nxt;
            generation_done <= retire_end;
            if (restart || retire_end) begin
                pc <= '0;
            end else if (advance) begin
                pc <= next_program_counter;
            end
            if (load_instr) begin
                instruction <= imem_data;
            end
            if (set_fault) begin
                fault <= 1'b1;
            end
        end
    end

    sequencer_stack #(
        .PC_WIDTH (PC_WIDTH),
        .SP_WIDTH (SP_WIDTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart || retire_end),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (pc_inc),
        .top_data  (stack_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed programs plus random ROMs, checked against an instruction-level model.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, branch_any, diverge_any;
    logic [11:0] imem_addr, next_program_counter;
    logic [15:0] imem_data, instruction;
    logic [4:0]  next_stack_pointer;
    logic        execution_enable, busy, generation_done, fault;

    logic [15:0] rom [0:4095];
    int n_vec = 0;
    int n_err = 0;

    program_sequencer #(
        .PC_WIDTH    (12),
        .SP_WIDTH    (5),
        .INSTR_WIDTH (16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .imem_addr            (imem_addr),
        .imem_data            (imem_data),
        .instruction          (instruction),
        .next_program_counter (next_program_counter),
        .next_stack_pointer   (next_stack_pointer),
        .execution_enable     (execution_enable),
        .branch_any           (branch_any),
        .diverge_any          (diverge_any),
        .busy                 (busy),
        .generation_done      (generation_done),
        .fault                (fault)
    );

    always #5 clk = ~clk;

    // Program ROM with one cycle of read latency
    always_ff @(posedge clk) imem_data <= rom[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [11:0] tgt);
        return {op, tgt};
    endfunction

    task automatic fill_rom_end();
        for (int i = 0; i < 4096; i++) rom[i] = enc(OP_END, 12'h000);
    endtask

    task automatic gen_random_rom();
        int r;
        logic [11:0] tg;
        fill_rom_end();
        for (int i = 0; i < 64; i++) begin
            r  = $urandom_range(0, 15);
            tg = 12'($urandom_range(0, 63));
            if (r < 4)       rom[i] = enc(OP_NOP, 12'($urandom));
            else if (r < 6)  rom[i] = enc(4'($urandom_range(6, 15)), 12'($urandom));
            else if (r < 8)  rom[i] = enc(OP_JMP, tg);
            else if (r < 10) rom[i] = enc(OP_BR, tg);
            else if (r < 12) rom[i] = enc(OP_CALL, tg);
            else if (r < 14) rom[i] = enc(OP_RET, tg);
            else             rom[i] = enc(OP_END, tg);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_exec_en"}, 32'(execution_enable), 32'(0));
        check_eq({tag, "_busy"},    32'(busy), 32'(0));
        check_eq({tag, "_done"},    32'(generation_done), 32'(0));
        check_eq({tag, "_fault"},   32'(fault), 32'(0));
        check_eq({tag, "_addr"},    32'(imem_addr), 32'(0));
        check_eq({tag, "_instr"},   32'(instruction), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // br_mode/dv_mode: 0 = hold low, 1 = hold high, 2 = random each cycle
    task automatic run_prog(input int budget, input int br_mode, input int dv_mode);
        logic [11:0] stk [$];
        logic [11:0] m_pc, npc;
        logic [15:0] ins;
        int nsp, tail;
        bit run, flt, done_exp, exp_ee, bad, fin;
        m_pc = '0; run = 1'b1; flt = 1'b0; done_exp = 1'b0; tail = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= budget; t++) begin
            branch_any  = (br_mode == 2) ? 1'($urandom_range(0, 1)) : (br_mode == 1);
            diverge_any = (dv_mode == 2) ? ($urandom_range(0, 7) == 0) : (dv_mode == 1);
            #1;
            exp_ee = run && (t % 2 == 0);
            check_eq("exec_en",  32'(execution_enable), 32'(exp_ee));
            check_eq("busy",     32'(busy), 32'(run));
            check_eq("gen_done", 32'(generation_done), 32'(done_exp));
            check_eq("fault",    32'(fault), 32'(flt));
            done_exp = 1'b0;
            if (exp_ee) begin
                ins = rom[m_pc];
                check_eq("instr", 32'(instruction), 32'(ins));
                npc = m_pc + 12'd1;
                nsp = stk.size();
                bad = 1'b0;
                fin = 1'b0;
                case (ins[15:12])
                    OP_JMP: npc = ins[11:0];
                    OP_BR:  if (branch_any) npc = ins[11:0];
                    OP_CALL: begin
                        if (stk.size() == 31) bad = 1'b1;
                        else begin
                            stk.push_back(m_pc + 12'd1);
                            npc = ins[11:0];
                            nsp++;
                        end
                    end
                    OP_RET: begin
                        if (stk.size() == 0) bad = 1'b1;
                        else begin
                            npc = stk.pop_back();
                            nsp--;
                        end
                    end
                    OP_END: begin
                        if (diverge_any) bad = 1'b1;
                        else fin = 1'b1;
                    end
                    default: ;
                endcase
                if (!bad || ins[15:12] == OP_END)
                    check_eq("next_pc", 32'(next_program_counter), 32'(npc));
                check_eq("next_sp", 32'(next_stack_pointer), 32'(nsp));
                if (bad) begin
                    flt = 1'b1;
                    run = 1'b0;
                end else if (fin) begin
                    run = 1'b0;
                    done_exp = 1'b1;
                end else begin
                    m_pc = npc;
                end
            end
            if (!run) begin
                tail++;
                if (tail > 3) break;
            end
            @(negedge clk);
        end
        if (flt) begin
            // A fault must swallow a new start request.
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #1;
                check_eq("flt_exec_en", 32'(execution_enable), 32'(0));
                check_eq("flt_sticky",  32'(fault), 32'(1));
                check_eq("flt_busy",    32'(busy), 32'(0));
                @(negedge clk);
            end
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        branch_any = 1'b0;
        diverge_any = 1'b0;
        fill_rom_end();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("init");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("idle_busy",    32'(busy), 32'(0));
            check_eq("idle_exec_en", 32'(execution_enable), 32'(0));
        end

        // NOP, NOP, END
        rom[0] = enc(OP_NOP, 12'h000);
        rom[1] = enc(OP_NOP, 12'h000);
        rom[2] = enc(OP_END, 12'h000);
        run_prog(20, 0, 0);

        // CALL / RET round trip
        fill_rom_end();
        rom[0]     = enc(OP_CALL, 12'h010);
        rom[1]     = enc(OP_END, 12'h000);
        rom[12'h010] = enc(OP_RET, 12'h000);
        run_prog(20, 0, 0);

        // Conditional branch taken and not taken
        fill_rom_end();
        rom[0]       = enc(OP_JMP, 12'h005);
        rom[5]       = enc(OP_BR, 12'h020);
        rom[6]       = enc(OP_END, 12'h000);
        rom[12'h020] = enc(OP_END, 12'h000);
        run_prog(20, 1, 0);
        run_prog(20, 0, 0);

        // Stack overflow after 31 nested calls, then underflow
        fill_rom_end();
        for (int i = 0; i < 32; i++) rom[i] = enc(OP_CALL, 12'(i + 1));
        run_prog(80, 0, 0);
        fill_rom_end();
        rom[0] = enc(OP_RET, 12'h000);
        run_prog(20, 0, 0);

        // PC wrap at the top of the address space
        fill_rom_end();
        rom[0]       = enc(OP_JMP, 12'hFFE);
        rom[12'hFFE] = enc(OP_NOP, 12'h000);
        rom[12'hFFF] = enc(OP_NOP, 12'h000);
        run_prog(12, 2, 0);

        // Divergence reported at END
        fill_rom_end();
        rom[0] = enc(OP_NOP, 12'h000);
        rom[1] = enc(OP_END, 12'h000);
        run_prog(20, 0, 1);

        // Reset in the middle of EXEC, then a clean rerun
        fill_rom_end();
        rom[0] = enc(OP_NOP, 12'h000);
        rom[1] = enc(OP_NOP, 12'h000);
        rom[2] = enc(OP_END, 12'h000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check_eq("pre_rst_exec_en", 32'(execution_enable), 32'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        run_prog(20, 0, 0);

        for (int p = 0; p < 40; p++) begin
            gen_random_rom();
            run_prog(300, 2, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
